// File: rtl/arith_unit.sv
// Sequential arithmetic unit: 1-cycle signed add/sub, W-cycle unsigned shift-add multiply / multiply-accumulate.
// Start/busy/done handshake; result and overflow are registered and only change on done edges or reset.
module arith_unit #(
  parameter int W = 8
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [1:0]     opcode,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] result,
  output logic           overflow
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_MAC = 2'b11;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_mac;
  logic [CW-1:0]   r_cnt;
  logic [2*W-1:0]  r_prod;

  logic [2*W-1:0]  w_a_ext;
  logic [2*W-1:0]  w_b_ext;
  logic [2*W-1:0]  w_sum;
  logic [2*W-1:0]  w_diff;
  logic [2*W-1:0]  w_addend;
  logic [2*W-1:0]  w_prod_next;
  logic [2*W:0]    w_acc;
  logic            w_last;

  assign w_a_ext     = {{W{a[W-1]}}, a};
  assign w_b_ext     = {{W{b[W-1]}}, b};
  assign w_sum       = w_a_ext + w_b_ext;
  assign w_diff      = w_b_ext - w_a_ext;
  assign w_addend    = r_b[r_cnt] ? ({{W{1'b0}}, r_a} << r_cnt) : '0;
  assign w_prod_next = r_prod + w_addend;
  // Extra top bit of the accumulate sum is the mac carry-out.
  assign w_acc       = {1'b0, result} + {1'b0, w_prod_next};
  assign w_last      = (r_cnt == CW'(W - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_mac    <= 1'b0;
      r_cnt    <= '0;
      r_prod   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            case (opcode)
              OP_ADD: begin
                result   <= w_sum;
                overflow <= 1'b0;
                done     <= 1'b1;
              end
              OP_SUB: begin
                result   <= w_diff;
                overflow <= 1'b0;
                done     <= 1'b1;
              end
              OP_MUL, OP_MAC: begin
                r_a     <= a;
                r_b     <= b;
                r_mac   <= opcode[1];
                r_cnt   <= '0;
                r_prod  <= '0;
                busy    <= 1'b1;
                r_state <= S_MUL;
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          r_prod <= w_prod_next;
          if (w_last) begin
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_IDLE;
            if (r_mac) begin
              result   <= w_acc[2*W-1:0];
              overflow <= w_acc[2*W];
            end else begin
              result   <= w_prod_next;
              overflow <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arith_unit.sv
// Directed bench for arith_unit (W=8): vector table for single-cycle ops, hand sequences for multiply/mac/reset.
module tb_arith_unit;
  localparam int W = 8;

  logic           clock = 1'b0;
  logic           reset;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [1:0]     opcode;
  logic           busy;
  logic           done;
  logic           overflow;
  logic [2*W-1:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  arith_unit #(.W(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .a        (a),
    .b        (b),
    .opcode   (opcode),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic [15:0] exp;
  } vec_t;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one multiply/mac and waits (bounded) for done; lat = edges after acceptance.
  task automatic do_mul(input logic [7:0] ia, input logic [7:0] ib, input logic [1:0] op, output int lat);
    a = ia; b = ib; opcode = op; start = 1'b1;
    step();
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      step();
      lat++;
    end
  endtask

  vec_t vecs[7];
  int   lat;
  int   pulses;
  int   busy_bad;

  initial begin
    vecs[0] = '{"add_m5_p3",   8'hFB, 8'h03, 2'b00, 16'hFFFE};
    vecs[1] = '{"sub_b_minus_a", 8'h03, 8'hFB, 2'b10, 16'hFFF8};
    vecs[2] = '{"sub_80_7f",   8'h7F, 8'h80, 2'b10, 16'hFF01};
    vecs[3] = '{"add_7f_7f",   8'h7F, 8'h7F, 2'b00, 16'h00FE};
    vecs[4] = '{"add_80_80",   8'h80, 8'h80, 2'b00, 16'hFF00};
    vecs[5] = '{"sub_7f_80",   8'h80, 8'h7F, 2'b10, 16'h00FF};
    vecs[6] = '{"add_ff_00",   8'hFF, 8'h00, 2'b00, 16'hFFFF};

    // Reset for two cycles, with a start held during reset that must lose.
    reset = 1'b1; start = 1'b0; a = '0; b = '0; opcode = 2'b00;
    step();
    a = 8'h01; b = 8'h01; start = 1'b1;
    step();
    check("rst_result",   32'(result),   32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    check("rst_done",     32'(done),     32'h0);
    check("rst_busy",     32'(busy),     32'h0);
    reset = 1'b0; start = 1'b0;
    step();
    check("idle_done", 32'(done), 32'h0);

    // Back-to-back single-cycle ops: done stays high, new result each cycle.
    for (int i = 0; i < 7; i++) begin
      a = vecs[i].a; b = vecs[i].b; opcode = vecs[i].op; start = 1'b1;
      step();
      check({vecs[i].name, "_result"}, 32'(result), 32'(vecs[i].exp));
      check({vecs[i].name, "_done"},   32'(done),   32'h1);
      check({vecs[i].name, "_ovf"},    32'(overflow), 32'h0);
      check({vecs[i].name, "_busy"},   32'(busy),   32'h0);
    end
    start = 1'b0;
    step();
    check("hold_done",   32'(done),   32'h0);
    check("hold_result", 32'(result), 32'hFFFF);

    // Multiply FF*FF with an add start pulsed mid-operation.
    a = 8'hFF; b = 8'hFF; opcode = 2'b01; start = 1'b1;
    step();
    start = 1'b0;
    pulses = 0; busy_bad = 0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 3) begin a = 8'h01; b = 8'h01; opcode = 2'b00; start = 1'b1; end
      if (k < 8 && (busy !== 1'b1 || done !== 1'b0)) busy_bad++;
      if (done) pulses++;
      step();
      start = 1'b0;
    end
    check("mul_busy_window", 32'(busy_bad), 32'h0);
    check("mul_done",   32'(done),   32'h1);
    check("mul_busy_end", 32'(busy), 32'h0);
    check("mul_result", 32'(result), 32'hFE01);
    check("mul_ovf",    32'(overflow), 32'h0);
    pulses++;
    for (int k = 0; k < 4; k++) begin
      step();
      if (done) pulses++;
    end
    check("mul_one_pulse", 32'(pulses), 32'h1);
    check("mul_hold",      32'(result), 32'hFE01);

    // Mac onto FE01.
    do_mul(8'h02, 8'h01, 2'b11, lat);
    check("mac1_lat",    32'(lat),      32'd8);
    check("mac1_result", 32'(result),   32'hFE03);
    check("mac1_ovf",    32'(overflow), 32'h0);

    // Load FFFF then mac 1*1 -> wrap with carry.
    a = 8'hFF; b = 8'h00; opcode = 2'b00; start = 1'b1;
    step();
    start = 1'b0;
    check("load_ffff", 32'(result), 32'hFFFF);
    do_mul(8'h01, 8'h01, 2'b11, lat);
    check("mac2_result", 32'(result),   32'h0000);
    check("mac2_ovf",    32'(overflow), 32'h1);
    a = 8'h01; b = 8'h01; opcode = 2'b00; start = 1'b1;
    step();
    start = 1'b0;
    check("add_clr_ovf",    32'(overflow), 32'h0);
    check("add_clr_result", 32'(result),   32'h0002);

    // Mac, then another mac issued in the done cycle.
    do_mul(8'h03, 8'h04, 2'b11, lat);
    check("mac3_result", 32'(result), 32'h000E);
    do_mul(8'h02, 8'h02, 2'b11, lat);
    check("mac4_lat",    32'(lat),    32'd8);
    check("mac4_result", 32'(result), 32'h0012);

    // Plain multiply with mixed bit pattern.
    do_mul(8'hA5, 8'h3C, 2'b01, lat);
    check("mul2_result", 32'(result), 32'h26AC);

    // Reset mid-multiply aborts without a done pulse.
    a = 8'h0F; b = 8'h0F; opcode = 2'b01; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_busy",   32'(busy),   32'h0);
    check("abort_result", 32'(result), 32'h0);
    check("abort_done",   32'(done),   32'h0);
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (done || busy) pulses++;
    end
    check("abort_no_done", 32'(pulses), 32'h0);
    do_mul(8'h03, 8'h05, 2'b01, lat);
    check("mul3_lat",    32'(lat),    32'd8);
    check("mul3_result", 32'(result), 32'h000F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/arith_unit.md
# arith_unit

Parametrised sequential arithmetic unit; successor to the team's 4-bit opcode-driven add/multiply/subtract block. It accepts two W-bit operands and a 2-bit opcode under a start/busy/done handshake. It performs single-cycle add and subtract and an iterative W-cycle shift-add multiply and multiply-accumulate, and returns a registered 2W-bit result. It sits between the operand/opcode entry logic and the display/result path.

## Interface
- W, default 8, operand width in bits; legal range 2..16.
- clock  input  1  rising-edge clock
- reset  input  1  reset, synchronous, active-high
- a  input  W  operand A; two's complement for add/sub, unsigned for mul/mac
- b  input  W  operand B; same encoding as a
- opcode  input  2  00 add, 01 multiply, 10 subtract, 11 multiply-accumulate
- start  input  1  request; sampled on rising edge
- busy  output  1  high while an iterative multiply/mac is in progress
- done  output  1  one-cycle pulse; result and overflow updated in the same cycle
- result  output  2W  registered result; holds value between done pulses
- overflow  output  1  registered carry-out of the mac accumulate; 0 for other ops

## Operation
- States: IDLE, MUL.
- Acceptance: start=1 at a rising edge with state=IDLE.
  - a, b and opcode are captured at acceptance.
  - start while busy=1 is ignored; it is not queued.
- Add (00): result = sext(a) + sext(b), computed to 2W bits.
  - Cannot overflow; overflow <= 0.
  - State stays IDLE.
- Subtract (10): result = sext(b) - sext(a), B minus A.
  - overflow <= 0.
- Multiply (01), unsigned:
  - Accept edge: state -> MUL; busy <= 1; iteration counter <= 0; partial product <= 0.
  - Each MUL edge adds (captured a << i) if bit i of captured b is 1, then increments the counter.
  - After W iterations: result <= product; overflow <= 0; state -> IDLE.
- Multiply-accumulate (11): same iteration as multiply.
  - Final edge: result <= (result + product) mod 2^(2W); overflow <= carry out of bit 2W-1.
  - The accumulator is the current result register value at completion.
- done <= 1 on the edge that writes result, and 0 on every other edge.
- result and overflow change only on done edges or on reset.
- Operand or opcode changes after acceptance have no effect on the operation in flight.

## Timing
- Reset values: result 0, overflow 0, done 0, busy 0, state IDLE, counter 0.
- Reset mid-operation (including during MUL) aborts: no done pulse, all outputs return to their reset values on the next edge.
- Reset has priority over start in the same cycle.
- Add/sub latency 1: start accepted at edge E0 -> done=1 and result valid in the cycle after E0.
  - busy stays 0, so add/sub can be issued every cycle; done is then high continuously with a new result each cycle.
- Multiply/mac latency W:
  - Accepted at edge E0; busy=1 from E0 through edge E(W-1).
  - Result written, done=1 and busy=0 after edge EW.
  - For W=8: done is high in the 8th cycle after acceptance.
- A start in the cycle where done=1 after a multiply is accepted; busy is already 0 in that cycle.
- A mac issued back-to-back after a mac accumulates onto the just-written result.

## Test plan
- Reset: assert reset for 2 cycles -> result=0x0000, overflow=0, done=0, busy=0.
- Add, W=8, a=0xFB (-5), b=0x03, opcode=00, start 1 cycle -> next cycle done=1, result=0xFFFE, overflow=0, busy=0 throughout.
- Subtract, a=0x03, b=0xFB, opcode=10 -> result=0xFFF8 (-8), done after 1 cycle. Then a=0x7F, b=0x80 -> result=0xFF01.
- Multiply, a=0xFF, b=0xFF, opcode=01:
  - busy high for 8 cycles, then done=1, result=0xFE01.
  - An add start pulsed at cycle 3 is ignored: exactly one done pulse, and the result is the product.
- Mac sequence: first leave result=0xFE01, then a=0x02, b=0x01, opcode=11 -> result=0xFE03, overflow=0.
  - Next, load result=0xFFFF via add a=0xFF, b=0x00, then mac a=0x01, b=0x01 -> result=0x0000, overflow=1.
  - A following add clears overflow to 0.
- Reset mid-multiply: start multiply a=0x0F, b=0x0F, assert reset at cycle 4 for 1 cycle -> busy=0, result=0, and no done pulse over the next 10 cycles.
  - A new multiply 3×5 then gives result=0x000F after 8 cycles.
